spi_slave: RTL and testbench

Oversampled SPI slave that is the far-end counterpart of the team's generic SPI master, used both as an on-chip responder and as the bench partner for the master. All SPI pins are synchronised into the single system clock domain and SCLK edges are detected there. Bit order is MSB first. Frame length, SCLK idle level and sampling phase are run-time inputs, so one instance covers every mode the master can generate.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/sync_edge_det.sv | 58 +++++
 rtl/spi_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_slave.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the oversampled SPI slave.
//   spi_state_e  : frame state (IDLE, ACTIVE, DONE)
//   SPI_MAX_BITS : longest supported frame
//   CNT_W        : width of the bit counter / latched frame length (0..32)
//   eff_bits()   : maps the raw nb_bits input onto a legal frame length
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_MAX_BITS = 32;
  localparam int CNT_W        = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_state_e;

  // Zero and anything above the maximum both mean a full-width frame.
  function automatic logic [CNT_W-1:0] eff_bits(input logic [7:0] nb);
    logic [CNT_W-1:0] r;
    if (nb == 8'd0 || nb > 8'(SPI_MAX_BITS)) begin
      r = CNT_W'(SPI_MAX_BITS);
    end else begin
      r = nb[CNT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// NSYNC-deep synchroniser for one asynchronous pin, with registered
// one-cycle rise/fall pulses.
//   clk, rst : system clock, asynchronous active-high reset
//   din      : asynchronous pin
//   level    : synchronised level (NSYNC cycles after the pin)
//   rise     : one-cycle pulse, NSYNC+1 cycles after a pin rising edge
//   fall     : one-cycle pulse, NSYNC+1 cycles after a pin falling edge
// NSYNC must be 2..4.
// The chain resets to 0, so a pin that is already low when reset is released
// never produces a fall pulse until it has first been seen high.
// ---------------------------------------------------------------------------
module sync_edge_det #(
  parameter int NSYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [NSYNC-1:0] sync_d, sync_q;
  logic             prev_d, prev_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;

  // Shift the pin through the synchroniser and compare the synced level with
  // its previous value to form registered edge pulses.
  always_comb begin
    sync_d = {sync_q[NSYNC-2:0], din};
    prev_d = sync_q[NSYNC-1];
    rise_d = sync_q[NSYNC-1] & ~prev_q;
    fall_d = ~sync_q[NSYNC-1] & prev_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q[NSYNC-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// Oversampled SPI slave, MSB first. All pins are synchronised into clk and
// SCLK edges are detected there. Frame length, SCLK idle level and phase are
// latched when chip select falls.
//   clk, rst   : system clock, asynchronous active-high reset
//   nb_bits    : bits per frame 1..32 (0 or >32 means 32)
//   y0_sclk    : SCLK idle level
//   cpha       : 0 sample on leading edge, 1 sample on trailing edge
//   tx_data    : response word, right-aligned
//   tx_ack     : one-cycle pulse when tx_data is latched
//   rx_data    : last complete received word, right-aligned
//   rx_valid   : one-cycle pulse when rx_data updates
//   err        : one-cycle pulse when a frame ends short
//   busy       : frame in progress (ACTIVE or DONE)
//   sclk, cs_n, mosi : SPI pins from the master
//   miso, miso_oe    : SPI response pin and its output enable
// ---------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int NSYNC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  nb_bits,
  input  logic        y0_sclk,
  input  logic        cpha,
  input  logic [31:0] tx_data,
  output logic        tx_ack,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        err,
  output logic        busy,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  sync_edge_det #(.NSYNC(NSYNC)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge_det #(.NSYNC(NSYNC)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge_det #(.NSYNC(NSYNC)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (mosi),
    .level (mosi_level),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  // Only the SCLK and chip-select edges and the MOSI level are needed.
  logic unused_sync;
  assign unused_sync = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

  spi_state_e       state_d, state_q;
  logic [CNT_W-1:0] nb_d, nb_q;
  logic             y0_d, y0_q;
  logic             cpha_d, cpha_q;
  logic [31:0]      tx_shift_d, tx_shift_q;
  logic [31:0]      rx_shift_d, rx_shift_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             miso_d, miso_q;
  logic [31:0]      rx_data_d, rx_data_q;
  logic             tx_ack_d, tx_ack_q;
  logic             rx_valid_d, rx_valid_q;
  logic             err_d, err_q;

  logic             lead_edge, trail_edge;
  logic             sample_edge, shift_edge;
  logic [CNT_W-1:0] nb_new;
  logic [CNT_W-1:0] align_sh;
  logic [31:0]      tx_aligned;
  logic [31:0]      sample_word;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_now;

  // Map the raw SCLK edges onto leading/trailing using the latched idle
  // level, then onto sample/shift using the latched phase. tx_data is
  // left-aligned at load so the next bit to send is always bit 31.
  always_comb begin
    lead_edge   = y0_q ? sclk_fall : sclk_rise;
    trail_edge  = y0_q ? sclk_rise : sclk_fall;
    sample_edge = cpha_q ? trail_edge : lead_edge;
    shift_edge  = cpha_q ? lead_edge : trail_edge;
    nb_new      = eff_bits(nb_bits);
    align_sh    = CNT_W'(SPI_MAX_BITS) - nb_new;
    tx_aligned  = tx_data << align_sh;
    sample_word = {rx_shift_q[30:0], mosi_level};
    cnt_inc     = cnt_q + CNT_W'(1);
  end

  // Next-state and output logic. A sample completing the frame in the same
  // cycle as chip select rising still counts as a good frame.
  always_comb begin
    state_d    = state_q;
    nb_d       = nb_q;
    y0_d       = y0_q;
    cpha_d     = cpha_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    cnt_d      = cnt_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    tx_ack_d   = 1'b0;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;
    done_now   = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          nb_d       = nb_new;
          y0_d       = y0_sclk;
          cpha_d     = cpha;
          rx_shift_d = '0;
          cnt_d      = '0;
          tx_ack_d   = 1'b1;
          state_d    = ACTIVE;
          // With cpha=0 the first bit is on the wire before any SCLK edge.
          if (cpha) begin
            miso_d     = 1'b0;
            tx_shift_d = tx_aligned;
          end else begin
            miso_d     = tx_aligned[31];
            tx_shift_d = tx_aligned << 1;
          end
        end
      end

      ACTIVE: begin
        if (sample_edge) begin
          rx_shift_d = sample_word;
          cnt_d      = cnt_inc;
          if (cnt_inc == nb_q) begin
            rx_data_d  = sample_word;
            rx_valid_d = 1'b1;
            state_d    = DONE;
            done_now   = 1'b1;
          end
        end
        if (shift_edge) begin
          miso_d     = tx_shift_q[31];
          tx_shift_d = tx_shift_q << 1;
        end
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          if (!done_now) begin
            err_d = 1'b1;
          end
        end
      end

      DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any frame in progress without a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      nb_q       <= CNT_W'(SPI_MAX_BITS);
      y0_q       <= 1'b0;
      cpha_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
      rx_data_q  <= '0;
      tx_ack_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nb_q       <= nb_d;
      y0_q       <= y0_d;
      cpha_q     <= cpha_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      rx_data_q  <= rx_data_d;
      tx_ack_q   <= tx_ack_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign miso_oe  = busy;
  assign miso     = busy & miso_q;
  assign tx_ack   = tx_ack_q;
  assign rx_valid = rx_valid_q;
  assign err      = err_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Self-checking bench for spi_slave: a table of directed frames, a reset
// corner case, and randomized frames checked against a bit-stream model.
// ---------------------------------------------------------------------------
module tb_spi_slave;

  localparam int NSYNC = 2;
  localparam int HALF  = 6;

  typedef struct {
    logic [7:0]  nb;
    logic        y0;
    logic        cpha;
    logic [31:0] tx;
    logic [63:0] stream;
    int          nsent;
    bit          merge;
    logic [31:0] exp_rx;
    int          exp_rxv;
    int          exp_err;
    logic [63:0] exp_read;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  nb_bits;
  logic        y0_sclk;
  logic        cpha;
  logic [31:0] tx_data;
  logic        tx_ack;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        err;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;

  int checks = 0;
  int errors = 0;
  int n_rxv  = 0;
  int n_err  = 0;
  int n_ack  = 0;

  always #5 clk = ~clk;

  spi_slave #(.NSYNC(NSYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .nb_bits  (nb_bits),
    .y0_sclk  (y0_sclk),
    .cpha     (cpha),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .err      (err),
    .busy     (busy),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe)
  );

  // Count the one-cycle pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) n_rxv++;
    if (err)      n_err++;
    if (tx_ack)   n_ack++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_nb(input logic [7:0] nb);
    return (nb == 8'd0 || nb > 8'd32) ? 32 : int'(nb);
  endfunction

  // Received word: the first nb bits of the MSB-first stream the master sent.
  function automatic logic [31:0] model_rx(input logic [63:0] stream, input int nsent, input int nb);
    logic [31:0] r = '0;
    for (int i = 0; i < nb; i++) r = {r[30:0], stream[nsent-1-i]};
    return r;
  endfunction

  // What the master reads: tx bits MSB first, then the last bit held.
  function automatic logic [63:0] model_read(input logic [31:0] tx, input int nb, input int nsent);
    logic [63:0] r = '0;
    for (int i = 0; i < nsent; i++) r = {r[62:0], (i < nb) ? tx[nb-1-i] : tx[0]};
    return r;
  endfunction

  function automatic vec_t mk_vec(input logic [7:0] nb, input logic y0, input logic ph,
                                  input logic [31:0] tx, input logic [63:0] stream,
                                  input int nsent, input bit merge, input logic [31:0] prev_rx);
    vec_t v;
    int   enb;
    enb        = model_nb(nb);
    v.nb       = nb;
    v.y0       = y0;
    v.cpha     = ph;
    v.tx       = tx;
    v.stream   = stream;
    v.nsent    = nsent;
    v.merge    = merge;
    v.exp_rxv  = (nsent >= enb) ? 1 : 0;
    v.exp_err  = (nsent >= enb) ? 0 : 1;
    v.exp_rx   = (nsent >= enb) ? model_rx(stream, nsent, enb) : prev_rx;
    v.exp_read = model_read(tx, enb, nsent);
    return v;
  endfunction

  // Master side of one frame. Optionally raises cs_n together with the last
  // trailing edge, and scrambles the config inputs once the frame has begun.
  task automatic applyStimulus(input int nsent, input logic y0, input logic ph,
                               input logic [63:0] stream, input bit merge, input bit scramble,
                               output logic [63:0] rd, output logic busy_pre);
    rd   = '0;
    sclk = y0;
    repeat (HALF) @(negedge clk);
    cs_n = 1'b0;
    if (!ph) mosi = stream[nsent-1];
    repeat (HALF) @(negedge clk);
    if (scramble) begin
      nb_bits = 8'($urandom);
      y0_sclk = 1'($urandom);
      cpha    = 1'($urandom);
      tx_data = $urandom;
    end
    for (int i = 0; i < nsent; i++) begin
      if (!ph) begin
        rd   = {rd[62:0], miso};
        sclk = ~y0;
        repeat (HALF) @(negedge clk);
        sclk = y0;
        if (i + 1 < nsent) mosi = stream[nsent-2-i];
        repeat (HALF) @(negedge clk);
      end else begin
        sclk = ~y0;
        mosi = stream[nsent-1-i];
        repeat (HALF) @(negedge clk);
        rd   = {rd[62:0], miso};
        sclk = y0;
        if (merge && i == nsent - 1) cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
      end
    end
    busy_pre = busy;
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic runVector(input string tag, input vec_t v, input bit scramble);
    int          rxv0, err0, ack0;
    logic [63:0] rd;
    logic        busy_pre;
    nb_bits = v.nb;
    y0_sclk = v.y0;
    cpha    = v.cpha;
    tx_data = v.tx;
    rxv0 = n_rxv;
    err0 = n_err;
    ack0 = n_ack;
    applyStimulus(v.nsent, v.y0, v.cpha, v.stream, v.merge, scramble, rd, busy_pre);
    checkOutput({tag, " rx_valid count"}, 64'(n_rxv - rxv0), 64'(v.exp_rxv));
    checkOutput({tag, " err count"},      64'(n_err - err0), 64'(v.exp_err));
    checkOutput({tag, " tx_ack count"},   64'(n_ack - ack0), 64'd1);
    checkOutput({tag, " rx_data"},        64'(rx_data), 64'(v.exp_rx));
    checkOutput({tag, " miso read"},      rd, v.exp_read);
    checkOutput({tag, " busy before cs"}, 64'(busy_pre), v.merge ? 64'd0 : 64'd1);
    checkOutput({tag, " busy after"},     64'({busy, miso_oe, miso}), 64'd0);
  endtask

  vec_t        vecs [8];
  vec_t        rv;
  logic [31:0] model_prev;

  initial begin
    int          rxv0, err0, ack0;
    int          enb, nsent, choice;
    logic        ph, y0;
    logic [63:0] stream;

    rst = 1'b1; nb_bits = 8'd8; y0_sclk = 1'b0; cpha = 1'b0; tx_data = '0;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;

    // Directed frames, expectations worked out by hand.
    vecs[0] = '{8'd8,  1'b0, 1'b0, 32'h0000_00A5, 64'h3C,        8,  1'b0, 32'h0000_003C, 1, 0, 64'hA5};
    vecs[1] = '{8'd32, 1'b1, 1'b1, 32'hDEAD_BEEF, 64'h1234_5678, 32, 1'b0, 32'h1234_5678, 1, 0, 64'hDEAD_BEEF};
    vecs[2] = '{8'd16, 1'b0, 1'b0, 32'h0000_A234, 64'hFFFF,      3,  1'b0, 32'h1234_5678, 0, 1, 64'h5};
    vecs[3] = '{8'd4,  1'b0, 1'b1, 32'h0000_0009, 64'h2D,        6,  1'b0, 32'h0000_000B, 1, 0, 64'h27};
    vecs[4] = '{8'd0,  1'b0, 1'b0, 32'h0F0F_0F0F, 64'h8000_0001, 32, 1'b0, 32'h8000_0001, 1, 0, 64'h0F0F_0F0F};
    vecs[5] = '{8'd8,  1'b0, 1'b1, 32'h0000_00C3, 64'h5A,        8,  1'b1, 32'h0000_005A, 1, 0, 64'hC3};
    vecs[6] = '{8'd40, 1'b1, 1'b0, 32'h0000_0001, 64'hCAFE_F00D, 32, 1'b0, 32'hCAFE_F00D, 1, 0, 64'h1};
    vecs[7] = '{8'd1,  1'b1, 1'b1, 32'h0000_0001, 64'h0,         1,  1'b0, 32'h0000_0000, 1, 0, 64'h1};

    repeat (3) @(negedge clk);
    checkOutput("reset tx_ack",   64'(tx_ack),   64'd0);
    checkOutput("reset rx_valid", 64'(rx_valid), 64'd0);
    checkOutput("reset err",      64'(err),      64'd0);
    checkOutput("reset busy",     64'(busy),     64'd0);
    checkOutput("reset miso",     64'({miso_oe, miso}), 64'd0);
    checkOutput("reset rx_data",  64'(rx_data),  64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Reset in the middle of a frame with cs_n still low afterwards.
    nb_bits = 8'd8; y0_sclk = 1'b0; cpha = 1'b0; tx_data = 32'h55;
    sclk = 1'b0; mosi = 1'b1;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      sclk = 1'b1; repeat (HALF) @(negedge clk);
      sclk = 1'b0; repeat (HALF) @(negedge clk);
    end
    checkOutput("midframe busy", 64'(busy), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rxv0 = n_rxv; err0 = n_err; ack0 = n_ack;
    checkOutput("post-reset rx_data", 64'(rx_data), 64'd0);
    for (int b = 0; b < 4; b++) begin
      sclk = 1'b1; repeat (HALF) @(negedge clk);
      sclk = 1'b0; repeat (HALF) @(negedge clk);
    end
    checkOutput("post-reset busy", 64'(busy), 64'd0);
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    checkOutput("post-reset pulses", 64'((n_rxv - rxv0) + (n_err - err0) + (n_ack - ack0)), 64'd0);
    runVector("after-reset", '{8'd8, 1'b1, 1'b1, 32'h3C, 64'hA7, 8, 1'b0, 32'hA7, 1, 0, 64'h3C}, 1'b0);

    // Randomized frames against the bit-stream model.
    model_prev = 32'hA7;
    for (int k = 0; k < 25; k++) begin
      nb_bits = 8'($urandom_range(0, 40));
      enb     = model_nb(nb_bits);
      choice  = $urandom_range(0, 3);
      if (choice == 0 && enb > 1) nsent = $urandom_range(1, enb - 1);
      else if (choice == 3)       nsent = enb + $urandom_range(1, 2);
      else                        nsent = enb;
      ph     = 1'($urandom);
      y0     = 1'($urandom);
      stream = {$urandom, $urandom};
      rv = mk_vec(nb_bits, y0, ph, $urandom, stream, nsent, 1'b0, model_prev);
      runVector($sformatf("rand%0d", k), rv, 1'b1);
      model_prev = rv.exp_rx;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
